// File: rtl/apu_pkg.sv
// Shared constants for the pulse-channel bank: length table, duty patterns, register offsets.
package apu_pkg;

    // Length counter load values indexed by the 5-bit length index.
    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // Waveform patterns; bit n is the output for duty step n.
    localparam logic [7:0] DUTY_TABLE [4] = '{8'h80, 8'hC0, 8'hF0, 8'h3F};

    // Register offsets within one channel's 4-byte window.
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_TLO  = 2'd1;
    localparam logic [1:0] REG_THI  = 2'd2;
    localparam logic [1:0] REG_LEN  = 2'd3;

endpackage

// File: rtl/apu_pulse_ch.sv
// One pulse channel: registers, period timer / duty sequencer, envelope, length counter and
// the registered output level.
module apu_pulse_ch
    import apu_pkg::*;
#(
    parameter int unsigned TIMER_W = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic         q_tick_i,
    input  logic         h_tick_i,
    input  logic         wr_en_i,
    input  logic [1:0]   wr_off_i,
    input  logic [7:0]   data_i,
    input  logic         en_i,      // next-state enable, so a clear acts on the write edge
    output logic [7:0]   ctrl_o,
    output logic [7:0]   tlo_o,
    output logic [7:0]   thi_o,
    output logic [7:0]   len_reg_o,
    output logic         len_nz_o,
    output logic [3:0]   level_o
);

    logic [7:0]         ctrl_q, ctrl_d, tlo_q, tlo_d, thi_q, thi_d, len_reg_q, len_reg_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [2:0]         duty_step_q, duty_step_d;
    logic               start_q, start_d;
    logic [3:0]         decay_q, decay_d, div_q, div_d;
    logic [7:0]         len_q, len_d;
    logic [3:0]         level_q, level_d;

    logic [TIMER_W-1:0] period;
    logic [3:0]         vol;
    logic               halt_loop, const_vol, len_wr;
    logic [7:0]         duty_pat;

    // Upper bits of the high timer byte fall away in the truncation.
    assign period    = TIMER_W'({thi_q, tlo_q});
    assign vol       = ctrl_q[3:0];
    assign const_vol = ctrl_q[4];
    assign halt_loop = ctrl_q[5];
    assign duty_pat  = DUTY_TABLE[ctrl_q[7:6]];
    assign len_wr    = wr_en_i && (wr_off_i == REG_LEN);

    // Next state for registers, timer, envelope, length counter and level.
    always_comb begin
        ctrl_d      = ctrl_q;
        tlo_d       = tlo_q;
        thi_d       = thi_q;
        len_reg_d   = len_reg_q;
        cnt_d       = cnt_q;
        duty_step_d = duty_step_q;
        start_d     = start_q;
        decay_d     = decay_q;
        div_d       = div_q;
        len_d       = len_q;
        level_d     = 4'd0;

        if (wr_en_i) begin
            unique case (wr_off_i)
                REG_CTRL: ctrl_d    = data_i;
                REG_TLO:  tlo_d     = data_i;
                REG_THI:  thi_d     = data_i;
                REG_LEN:  len_reg_d = data_i;
            endcase
        end

        if (tick_i) begin
            if (cnt_q == '0) begin
                cnt_d       = period;
                duty_step_d = duty_step_q - 3'd1;
            end else begin
                cnt_d = cnt_q - TIMER_W'(1);
            end
        end

        if (q_tick_i) begin
            if (start_q) begin
                start_d = 1'b0;
                decay_d = 4'd15;
                div_d   = vol;
            end else if (div_q == 4'd0) begin
                div_d = vol;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (halt_loop) begin
                    decay_d = 4'd15;
                end
            end else begin
                div_d = div_q - 4'd1;
            end
        end

        if (h_tick_i && !halt_loop && (len_q != 8'd0)) begin
            len_d = len_q - 8'd1;
        end

        // Priority: disable > length write > h_tick decrement.
        if (len_wr) begin
            duty_step_d = 3'd0;
            start_d     = 1'b1;
            if (en_i) begin
                len_d = LEN_TABLE[data_i[7:3]];
            end
        end
        if (!en_i) begin
            len_d = 8'd0;
        end

        if (en_i && (len_q != 8'd0) && (period >= TIMER_W'(8)) && duty_pat[duty_step_q]) begin
            level_d = const_vol ? vol : decay_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q      <= 8'd0;
            tlo_q       <= 8'd0;
            thi_q       <= 8'd0;
            len_reg_q   <= 8'd0;
            cnt_q       <= '0;
            duty_step_q <= 3'd0;
            start_q     <= 1'b0;
            decay_q     <= 4'd0;
            div_q       <= 4'd0;
            len_q       <= 8'd0;
            level_q     <= 4'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            tlo_q       <= tlo_d;
            thi_q       <= thi_d;
            len_reg_q   <= len_reg_d;
            cnt_q       <= cnt_d;
            duty_step_q <= duty_step_d;
            start_q     <= start_d;
            decay_q     <= decay_d;
            div_q       <= div_d;
            len_q       <= len_d;
            level_q     <= level_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign tlo_o     = tlo_q;
    assign thi_o     = thi_q;
    assign len_reg_o = len_reg_q;
    assign len_nz_o  = (len_q != 8'd0);
    assign level_o   = level_q;

endmodule

// File: rtl/apu_pulse_bank.sv
// Bank of pulse channels on a byte-wide register bus, with shared prescaler and frame
// sequencer, the ENABLE register, a registered read port and a registered mix sum.
module apu_pulse_bank
    import apu_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TIMER_W   = 11,
    parameter int unsigned PRESCALE  = 2,
    parameter int unsigned FRAME_DIV = 7457,
    localparam int unsigned ADDR_W   = $clog2(4 * N_CH + 1),
    localparam int unsigned MIX_W    = $clog2(15 * N_CH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        data_i,
    input  logic              write_i,
    output logic [7:0]        data_o,
    output logic [4*N_CH-1:0] level_o,
    output logic [MIX_W-1:0]  mix_o
);

    localparam int unsigned PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FR_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned EN_ADDR = 4 * N_CH;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic [1:0]        step_q, step_d;
    logic [N_CH-1:0]   enable_q, enable_d;
    logic [7:0]        data_q, data_d;
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic              tick, q_tick, h_tick;
    logic [31:0]       addr_ext;
    logic [7:0]        rdata;
    logic [N_CH-1:0]   ch_wr, len_nz;
    logic [7:0]        ch_ctrl [N_CH];
    logic [7:0]        ch_tlo [N_CH];
    logic [7:0]        ch_thi [N_CH];
    logic [7:0]        ch_len [N_CH];

    assign addr_ext = 32'(addr_i);
    assign tick     = (pre_q == PRE_W'(PRESCALE - 1));
    assign q_tick   = tick && (frame_q == FR_W'(FRAME_DIV - 1));
    // The new step is odd exactly when the current step is even.
    assign h_tick   = q_tick && !step_q[0];

    // Prescaler, frame sequencer and ENABLE next state.
    always_comb begin
        pre_d    = tick ? '0 : pre_q + PRE_W'(1);
        frame_d  = frame_q;
        step_d   = step_q;
        enable_d = enable_q;
        if (tick) begin
            frame_d = q_tick ? '0 : frame_q + FR_W'(1);
        end
        if (q_tick) begin
            step_d = step_q + 2'd1;
        end
        if (write_i && (addr_ext == EN_ADDR)) begin
            enable_d = data_i[N_CH-1:0];
        end
    end

    // Channel write strobes.
    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            ch_wr[k] = write_i && (addr_ext < EN_ADDR) && ((addr_ext >> 2) == k);
        end
    end

    // Read mux; data_o only updates on read cycles.
    always_comb begin
        rdata = 8'h00;
        if (addr_ext < EN_ADDR) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if ((addr_ext >> 2) == k) begin
                    unique case (addr_i[1:0])
                        REG_CTRL: rdata = ch_ctrl[k];
                        REG_TLO:  rdata = ch_tlo[k];
                        REG_THI:  rdata = ch_thi[k];
                        REG_LEN:  rdata = ch_len[k];
                    endcase
                end
            end
        end else if (addr_ext == EN_ADDR) begin
            rdata = 8'(len_nz);
        end
        data_d = write_i ? data_q : rdata;
    end

    // Mix sum over the registered channel levels.
    always_comb begin
        mix_d = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            mix_d = mix_d + MIX_W'(level_o[4*k +: 4]);
        end
    end

    // Top-level state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q    <= '0;
            frame_q  <= '0;
            step_q   <= 2'd0;
            enable_q <= '0;
            data_q   <= 8'h00;
            mix_q    <= '0;
        end else begin
            pre_q    <= pre_d;
            frame_q  <= frame_d;
            step_q   <= step_d;
            enable_q <= enable_d;
            data_q   <= data_d;
            mix_q    <= mix_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        apu_pulse_ch #(
            .TIMER_W (TIMER_W)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tick_i    (tick),
            .q_tick_i  (q_tick),
            .h_tick_i  (h_tick),
            .wr_en_i   (ch_wr[k]),
            .wr_off_i  (addr_i[1:0]),
            .data_i    (data_i),
            .en_i      (enable_d[k]),
            .ctrl_o    (ch_ctrl[k]),
            .tlo_o     (ch_tlo[k]),
            .thi_o     (ch_thi[k]),
            .len_reg_o (ch_len[k]),
            .len_nz_o  (len_nz[k]),
            .level_o   (level_o[4*k +: 4])
        );
    end

    assign data_o = data_q;
    assign mix_o  = mix_q;

endmodule

// File: tb/tb_apu_pulse_bank.sv
// Self-checking bench for apu_pulse_bank with a shortened frame divider.
module tb_apu_pulse_bank;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned TIMER_W   = 11;
    localparam int unsigned PRESCALE  = 2;
    localparam int unsigned FRAME_DIV = 16;
    localparam int unsigned ADDR_W    = $clog2(4 * N_CH + 1);
    localparam int unsigned MIX_W     = $clog2(15 * N_CH + 1);
    localparam int unsigned IDLE_A    = 31;
    localparam int unsigned EN_A      = 16;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [ADDR_W-1:0] addr_i = ADDR_W'(IDLE_A);
    logic [7:0]        data_i = 8'h00;
    logic              write_i = 1'b0;
    logic [7:0]        data_o;
    logic [4*N_CH-1:0] level_o;
    logic [MIX_W-1:0]  mix_o;

    apu_pulse_bank #(
        .N_CH      (N_CH),
        .TIMER_W   (TIMER_W),
        .PRESCALE  (PRESCALE),
        .FRAME_DIV (FRAME_DIV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .write_i (write_i),
        .data_o  (data_o),
        .level_o (level_o),
        .mix_o   (mix_o)
    );

    always #5 clk = ~clk;

    // Posedges since reset release.
    int unsigned cyc;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [7:0]  exp_q[$];

    typedef struct {
        bit          wr;
        int unsigned addr;
        logic [7:0]  wdata;
        logic [7:0]  rexp;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input int unsigned got, input int unsigned expv);
        n_total++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    endtask

    function automatic int unsigned lvl(input int unsigned k);
        return 32'(level_o[4*k +: 4]);
    endfunction

    function automatic int unsigned lvl_sum();
        int unsigned s = 0;
        for (int unsigned k = 0; k < N_CH; k++) s += lvl(k);
        return s;
    endfunction

    // All bus tasks start and end on a negedge; a write lands on the next posedge.
    task automatic wr(input int unsigned a, input logic [7:0] d);
        addr_i  = ADDR_W'(a);
        data_i  = d;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        addr_i  = ADDR_W'(IDLE_A);
    endtask

    task automatic rd(input string name, input int unsigned a, input logic [7:0] e);
        addr_i  = ADDR_W'(a);
        write_i = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        chk(name, 32'(data_o), 32'(exp_q.pop_front()));
        addr_i = ADDR_W'(IDLE_A);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned n, mx, prev;

        vecs[0]  = '{1'b1, 0,    8'hA5, 8'hA5};
        vecs[1]  = '{1'b1, 1,    8'h3C, 8'h3C};
        vecs[2]  = '{1'b1, 2,    8'hFF, 8'hFF};
        vecs[3]  = '{1'b1, 3,    8'hF9, 8'hF9};
        vecs[4]  = '{1'b1, 5,    8'h12, 8'h12};
        vecs[5]  = '{1'b1, 15,   8'h80, 8'h80};
        vecs[6]  = '{1'b1, 17,   8'h55, 8'h00};
        vecs[7]  = '{1'b1, 31,   8'hAA, 8'h00};
        vecs[8]  = '{1'b1, EN_A, 8'h0F, 8'h00};
        vecs[9]  = '{1'b1, 7,    8'h08, 8'h08};
        vecs[10] = '{1'b0, EN_A, 8'h00, 8'h02};
        vecs[11] = '{1'b1, EN_A, 8'h00, 8'h00};
        vecs[12] = '{1'b1, EN_A, 8'h0F, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_level_o", 32'(level_o), 0);
        chk("rst_mix_o", 32'(mix_o), 0);
        rst_ni = 1'b1;
        rd("rst_enable", EN_A, 8'h00);

        // Register map vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rexp);
        end
        rd("hold_pre", 0, 8'hA5);
        addr_i  = ADDR_W'(1);
        data_i  = 8'h77;
        write_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        addr_i  = ADDR_W'(IDLE_A);
        chk("hold_data_o", 32'(data_o), 8'hA5);

        // Constant-volume tone, duty 2, period 16
        do_reset();
        wr(EN_A, 8'h01); wr(0, 8'h90); wr(0, 8'h9F); wr(1, 8'h10); wr(2, 8'h00); wr(3, 8'h08);
        @(negedge clk);
        chk("tone_start_low", lvl(0), 0);
        n = 0;
        while (lvl(0) != 15 && n < 400) begin @(negedge clk); n++; end
        chk("tone_rise", lvl(0), 15);
        n = 0;
        while (lvl(0) == 15 && n < 400) begin @(negedge clk); n++; end
        chk("tone_high_cycles", n, 136);
        chk("tone_fall_level", lvl(0), 0);
        n = 0;
        while (lvl(0) == 0 && n < 400) begin @(negedge clk); n++; end
        chk("tone_low_cycles", n, 136);
        chk("tone_other_ch", 32'(level_o[4*N_CH-1:4]), 0);

        // Length expiry: len 2, two h_ticks
        wr(0, 8'h9F); wr(3, 8'h18);
        rd("len_live", EN_A, 8'h01);
        repeat (35) @(negedge clk);
        rd("len_live2", EN_A, 8'h01);
        repeat (100) @(negedge clk);
        rd("len_expired", EN_A, 8'h00);
        chk("len_expired_level", lvl(0), 0);
        // Halt keeps the counter
        wr(0, 8'hBF); wr(3, 8'h18);
        repeat (200) @(negedge clk);
        rd("len_halt", EN_A, 8'h01);

        // Period 7 mutes, period 8 plays
        do_reset();
        wr(EN_A, 8'h01); wr(0, 8'h9F); wr(1, 8'h07); wr(3, 8'h08);
        mx = 0;
        repeat (300) begin @(negedge clk); if (lvl(0) > mx) mx = lvl(0); end
        chk("period7_mute", mx, 0);
        wr(1, 8'h08);
        n = 0;
        while (lvl(0) != 15 && n < 300) begin @(negedge clk); n++; end
        chk("period8_audible", lvl(0), 15);

        // Disabled channel ignores a length write
        wr(EN_A, 8'h00);
        rd("en_clear", EN_A, 8'h00);
        wr(3, 8'h08);
        rd("en_clear_len_wr", EN_A, 8'h00);
        @(negedge clk);
        chk("en_clear_level", lvl(0), 0);

        // Length write on the same edge as an h_tick (posedges 32, 96, 160, 224)
        do_reset();
        wr(EN_A, 8'h01); wr(0, 8'h9F); wr(3, 8'h18);
        wait_cyc(95);
        wr(3, 8'h18);
        wait_cyc(99);
        rd("htick_wr_100", EN_A, 8'h01);
        wait_cyc(199);
        rd("htick_wr_200", EN_A, 8'h01);
        wait_cyc(239);
        rd("htick_wr_240", EN_A, 8'h00);

        // Envelope, period 1, duty 3 held at step 0
        do_reset();
        wr(EN_A, 8'h01); wr(0, 8'hC1); wr(2, 8'h07);
        repeat (4) @(negedge clk);
        wr(3, 8'h08);
        n = 0;
        while (lvl(0) != 15 && n < 200) begin @(negedge clk); n++; end
        chk("env_start", lvl(0), 15);
        for (int e = 14; e >= 0; e--) begin
            prev = lvl(0);
            n = 0;
            while (lvl(0) == prev && n < 200) begin @(negedge clk); n++; end
            chk($sformatf("env_decay%0d", e), lvl(0), e);
            chk($sformatf("env_interval%0d", e), n, 64);
        end
        mx = 0;
        repeat (200) begin @(negedge clk); if (lvl(0) > mx) mx = lvl(0); end
        chk("env_hold0", mx, 0);
        wr(0, 8'hE1);
        n = 0;
        while (lvl(0) == 0 && n < 200) begin @(negedge clk); n++; end
        chk("env_loop", lvl(0), 15);

        // Mix of four const-15 duty-3 channels
        do_reset();
        wr(EN_A, 8'h0F);
        for (int unsigned k = 0; k < N_CH; k++) begin
            wr(4 * k, 8'hDF); wr(4 * k + 1, 8'h10); wr(4 * k + 3, 8'h08);
        end
        n = 0;
        while (level_o != 16'hFFFF && n < 600) begin @(negedge clk); n++; end
        chk("mix_all_on", 32'(level_o), 32'hFFFF);
        @(negedge clk);
        chk("mix_60", 32'(mix_o), 60);
        for (int i = 0; i < 40; i++) begin
            prev = lvl_sum();
            @(negedge clk);
            chk("mix_follow", 32'(mix_o), prev);
        end

        // Asynchronous reset mid-note
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_level", 32'(level_o), 0);
        chk("async_rst_mix", 32'(mix_o), 0);
        chk("async_rst_data", 32'(data_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        mx = 0;
        repeat (200) begin @(negedge clk); if (lvl_sum() > mx) mx = lvl_sum(); end
        chk("post_rst_silent", mx, 0);
        rd("post_rst_enable", EN_A, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
